// File: rtl/sha_stream_padder_if.sv
// Handshake and bus bundle between the boot word producer, the padder and the SHA-256 core.
// The master modport is the environment side; slave is the padder.
interface sha_stream_padder_if;
    logic         msg_valid;
    logic         msg_ready;
    logic [31:0]  msg_data;
    logic         msg_last;
    logic         sha_ready;
    logic         sha_digest_valid;
    logic [255:0] sha_digest;
    logic [511:0] sha_block;
    logic         sha_init;
    logic         sha_next;
    logic [255:0] digest_out;
    logic         digest_done;
    logic         busy;
    logic         overflow_err;

    modport master (
        output msg_valid, msg_data, msg_last, sha_ready, sha_digest_valid, sha_digest,
        input  msg_ready, sha_block, sha_init, sha_next, digest_out, digest_done, busy, overflow_err
    );

    modport slave (
        input  msg_valid, msg_data, msg_last, sha_ready, sha_digest_valid, sha_digest,
        output msg_ready, sha_block, sha_init, sha_next, digest_out, digest_done, busy, overflow_err
    );
endinterface

// File: rtl/sha_stream_padder.sv
// Packs 32-bit big-endian words into 512-bit SHA-256 blocks, applies FIPS 180-4 padding,
// sequences sha_init/sha_next against sha_ready and captures the final digest.
module sha_stream_padder #(
    parameter int MAX_WORDS = 65536
) (
    input  logic                 clk,
    input  logic                 rst,
    sha_stream_padder_if.slave   bus
);
    localparam int CNT_W = $clog2(MAX_WORDS) + 1;

    typedef enum logic [2:0] {IDLE, FILL, ISSUE, WAIT_LO, WAIT_RDY, PAD, LEN, WAIT_DIG} state_t;

    state_t              state_q;
    logic [15:0][31:0]   blk_q;      // element 15 is word 0 (bits 511:480)
    logic [3:0]          idx_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [63:0]         bitlen_q;
    logic [63:0]         bitlen_d;
    logic                first_q, final_q, padp_q, lenp_q;
    logic                msg_ready_q, init_q, next_q, done_q, busy_q, ovf_q;
    logic [255:0]        digest_q;
    logic                accept;

    assign accept   = bus.msg_valid && msg_ready_q;
    assign cnt_d    = cnt_q + 1'b1;
    assign bitlen_d = bitlen_q + 64'd32;

    // Terminator at word n, zeros above it, and the length in words 14/15 when it fits.
    function automatic logic [15:0][31:0] pad_blk(input logic [15:0][31:0] b,
                                                   input logic [3:0] n,
                                                   input logic [63:0] len);
        logic [15:0][31:0] r;
        r = b;
        for (int k = 0; k < 16; k++) begin
            if (4'(k) == n)
                r[4'(15 - k)] = 32'h8000_0000;
            else if (4'(k) > n)
                r[4'(15 - k)] = '0;
        end
        if (n <= 4'd13) begin
            r[1] = len[63:32];
            r[0] = len[31:0];
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            blk_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            bitlen_q    <= '0;
            first_q     <= 1'b0;
            final_q     <= 1'b0;
            padp_q      <= 1'b0;
            lenp_q      <= 1'b0;
            msg_ready_q <= 1'b0;
            init_q      <= 1'b0;
            next_q      <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
            digest_q    <= '0;
        end else begin
            init_q <= 1'b0;
            next_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    msg_ready_q <= 1'b1;
                    if (accept) begin
                        blk_q[15] <= bus.msg_data;
                        idx_q     <= 4'd1;
                        cnt_q     <= CNT_W'(1);
                        bitlen_q  <= 64'd32;
                        busy_q    <= 1'b1;
                        first_q   <= 1'b1;
                        final_q   <= 1'b0;
                        padp_q    <= 1'b0;
                        lenp_q    <= 1'b0;
                        if (bus.msg_last) begin
                            state_q     <= PAD;
                            msg_ready_q <= 1'b0;
                        end else begin
                            state_q <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (accept) begin
                        if (cnt_q == CNT_W'(MAX_WORDS)) begin
                            // Oversized message: abandon it without a digest.
                            ovf_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            blk_q[4'd15 - idx_q] <= bus.msg_data;
                            idx_q    <= idx_q + 4'd1;
                            cnt_q    <= cnt_d;
                            bitlen_q <= bitlen_d;
                            if (idx_q == 4'd15) begin
                                state_q     <= ISSUE;
                                msg_ready_q <= 1'b0;
                                final_q     <= 1'b0;
                                padp_q      <= bus.msg_last;
                            end else if (bus.msg_last) begin
                                state_q     <= PAD;
                                msg_ready_q <= 1'b0;
                            end
                        end
                    end
                end
                PAD: begin
                    blk_q   <= pad_blk(blk_q, idx_q, bitlen_q);
                    final_q <= (idx_q <= 4'd13);
                    lenp_q  <= (idx_q >= 4'd14);
                    state_q <= ISSUE;
                end
                LEN: begin
                    blk_q   <= {448'd0, bitlen_q};
                    final_q <= 1'b1;
                    lenp_q  <= 1'b0;
                    state_q <= ISSUE;
                end
                ISSUE: begin
                    if (bus.sha_ready) begin
                        init_q  <= first_q;
                        next_q  <= !first_q;
                        first_q <= 1'b0;
                        state_q <= WAIT_LO;
                    end
                end
                // The core needs a cycle to drop sha_ready after the pulse.
                WAIT_LO: state_q <= WAIT_RDY;
                WAIT_RDY: begin
                    if (bus.sha_ready) begin
                        if (final_q) begin
                            if (bus.sha_digest_valid) begin
                                digest_q    <= bus.sha_digest;
                                done_q      <= 1'b1;
                                busy_q      <= 1'b0;
                                msg_ready_q <= 1'b1;
                                state_q     <= IDLE;
                            end else begin
                                state_q <= WAIT_DIG;
                            end
                        end else if (padp_q) begin
                            padp_q  <= 1'b0;
                            idx_q   <= '0;
                            state_q <= PAD;
                        end else if (lenp_q) begin
                            state_q <= LEN;
                        end else begin
                            idx_q       <= '0;
                            msg_ready_q <= 1'b1;
                            state_q     <= FILL;
                        end
                    end
                end
                WAIT_DIG: begin
                    if (bus.sha_digest_valid) begin
                        digest_q    <= bus.sha_digest;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        msg_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.msg_ready    = msg_ready_q;
    assign bus.sha_block    = blk_q;
    assign bus.sha_init     = init_q;
    assign bus.sha_next     = next_q;
    assign bus.digest_out   = digest_q;
    assign bus.digest_done  = done_q;
    assign bus.busy         = busy_q;
    assign bus.overflow_err = ovf_q;
endmodule

// File: tb/tb_sha_stream_padder.sv
// Bench for sha_stream_padder: random messages against a word-list padding model, plus a
// simple SHA core responder with programmable busy time and digest lag.
module tb_sha_stream_padder;
    localparam int MAXW = 24;

    logic clk;
    logic rst;
    sha_stream_padder_if bus();

    sha_stream_padder #(.MAX_WORDS(MAXW)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Responder and monitor state
    int          m_dly = 2;
    int          m_lag = 0;
    int          m_cnt;
    int          m_ph;
    logic [31:0] m_seq = 32'd1;
    logic [31:0] salt  = 32'h1234_5678;
    logic [511:0] blk_log[$];
    logic [1:0]   kind_log[$];
    int           done_n = 0;
    int           viol_n = 0;
    logic [255:0] cap_dig;
    logic [31:0]  msg_q[$];

    function automatic logic [255:0] mk_dig(input logic [31:0] s);
        return {salt ^ s, s, ~s, salt, s * 32'h9E37_79B9, 32'hA5A5_A5A5 ^ s, s + 32'd7, ~salt};
    endfunction

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            bus.sha_ready        <= 1'b1;
            bus.sha_digest_valid <= 1'b0;
            bus.sha_digest       <= '0;
            m_cnt                <= 0;
            m_ph                 <= 0;
        end else if (bus.sha_init || bus.sha_next) begin
            bus.sha_ready        <= 1'b0;
            bus.sha_digest_valid <= 1'b0;
            m_cnt                <= m_dly;
            m_ph                 <= 1;
        end else if (m_ph == 1) begin
            if (m_cnt <= 1) begin
                bus.sha_ready <= 1'b1;
                if (m_lag == 0) begin
                    bus.sha_digest_valid <= 1'b1;
                    bus.sha_digest       <= mk_dig(m_seq);
                    m_seq                <= m_seq + 32'd1;
                    m_ph                 <= 0;
                end else begin
                    m_cnt <= m_lag;
                    m_ph  <= 2;
                end
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (m_ph == 2) begin
            if (m_cnt <= 1) begin
                bus.sha_digest_valid <= 1'b1;
                bus.sha_digest       <= mk_dig(m_seq);
                m_seq                <= m_seq + 32'd1;
                m_ph                 <= 0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.sha_init || bus.sha_next) begin
            blk_log.push_back(bus.sha_block);
            kind_log.push_back({bus.sha_init, bus.sha_next});
        end
        if (bus.digest_done) begin
            done_n  <= done_n + 1;
            cap_dig <= bus.digest_out;
        end
        if (bus.busy && !bus.sha_ready && bus.msg_ready) viol_n <= viol_n + 1;
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends n words starting at a negedge; returns at a negedge with valid low.
    task automatic send_words(input int n, input bit with_last, input int gap, input logic [31:0] fix);
        logic [31:0] w;
        int cyc;
        for (int i = 0; i < n; i++) begin
            if (gap > 0) repeat ($urandom_range(gap, 0)) @(negedge clk);
            w = (fix != 32'd0) ? fix + 32'(i) : $urandom;
            bus.msg_valid = 1'b1;
            bus.msg_data  = w;
            bus.msg_last  = with_last && (i == n - 1);
            cyc = 0;
            while (!bus.msg_ready && cyc < 400) begin
                @(negedge clk);
                cyc++;
            end
            if (!bus.msg_ready) begin
                chk("handshake_timeout", 512'(bus.msg_ready), 512'd1);
                bus.msg_valid = 1'b0;
                bus.msg_last  = 1'b0;
                return;
            end
            msg_q.push_back(w);
            @(negedge clk);
            bus.msg_valid = 1'b0;
            bus.msg_last  = 1'b0;
        end
    endtask

    // Reference: message words, 0x80000000, zero fill to 14 mod 16, 64-bit bit length.
    task automatic check_blocks(input string tag, input int b0);
        logic [31:0]  p[$];
        logic [63:0]  bl;
        logic [511:0] e;
        int nb;
        p  = msg_q;
        bl = 64'(msg_q.size()) * 64'd32;
        p.push_back(32'h8000_0000);
        while (p.size() % 16 != 14) p.push_back(32'd0);
        p.push_back(bl[63:32]);
        p.push_back(bl[31:0]);
        nb = p.size() / 16;
        chk({tag, "_nblocks"}, 512'(blk_log.size() - b0), 512'(nb));
        for (int b = 0; b < nb && (b0 + b) < blk_log.size(); b++) begin
            e = '0;
            for (int k = 0; k < 16; k++) e = {e[479:0], p[b * 16 + k]};
            chk($sformatf("%s_blk%0d", tag, b), blk_log[b0 + b], e);
            chk($sformatf("%s_kind%0d", tag, b), 512'(kind_log[b0 + b]), (b == 0) ? 512'd2 : 512'd1);
        end
    endtask

    task automatic run_msg(input string tag, input int n, input int dly, input int lag,
                           input int gap, input logic [31:0] fix, input bit exp_ovf);
        int b0, d0, v0, cyc;
        msg_q.delete();
        m_dly = dly;
        m_lag = lag;
        b0 = blk_log.size();
        d0 = done_n;
        v0 = viol_n;
        send_words(n, 1'b1, gap, fix);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (bus.busy && cyc < 3000);
        chk({tag, "_busy_end"}, 512'(bus.busy), 512'd0);
        repeat (2) @(posedge clk);
        #1;
        check_blocks(tag, b0);
        chk({tag, "_done_count"}, 512'(done_n - d0), 512'd1);
        chk({tag, "_digest_out"}, 512'(bus.digest_out), 512'(bus.sha_digest));
        chk({tag, "_digest_at_pulse"}, 512'(cap_dig), 512'(bus.sha_digest));
        chk({tag, "_ready_during_wait"}, 512'(viol_n - v0), 512'd0);
        chk({tag, "_overflow"}, 512'(bus.overflow_err), 512'(exp_ovf));
        chk({tag, "_ready_idle"}, 512'(bus.msg_ready), 512'd1);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk({tag, "_ctrl"}, 512'({bus.msg_ready, bus.sha_init, bus.sha_next,
                                  bus.digest_done, bus.busy, bus.overflow_err}), 512'd0);
        chk({tag, "_block"}, bus.sha_block, 512'd0);
        chk({tag, "_digest"}, 512'(bus.digest_out), 512'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, d0, cyc;
        rst           = 1'b1;
        bus.msg_valid = 1'b0;
        bus.msg_data  = '0;
        bus.msg_last  = 1'b0;
        salt          = $urandom;
        repeat (2) @(negedge clk);
        do_reset("reset");

        run_msg("w1",  1,  3, 0, 0, 32'h6162_6364, 1'b0);
        run_msg("w13", 13, 2, 2, 1, 32'd0, 1'b0);
        run_msg("w14", 14, 2, 0, 0, 32'd0, 1'b0);
        run_msg("w15", 15, 1, 1, 0, 32'd0, 1'b0);
        run_msg("w16", 16, 2, 3, 1, 32'd0, 1'b0);
        run_msg("w20", 20, 10, 0, 2, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++)
            run_msg($sformatf("rnd%0d", i), $urandom_range(MAXW, 1), $urandom_range(6, 1),
                    $urandom_range(3, 0), $urandom_range(2, 0), 32'd0, 1'b0);
        run_msg("w24max", MAXW, 2, 1, 0, 32'd0, 1'b0);

        // One word beyond the limit aborts without a digest.
        msg_q.delete();
        m_dly = 2;
        m_lag = 0;
        b0 = blk_log.size();
        d0 = done_n;
        send_words(MAXW + 1, 1'b0, 1, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("ovf_flag", 512'(bus.overflow_err), 512'd1);
        chk("ovf_busy", 512'(bus.busy), 512'd0);
        chk("ovf_no_done", 512'(done_n - d0), 512'd0);
        chk("ovf_blocks", 512'(blk_log.size() - b0), 512'd1);
        @(negedge clk);
        run_msg("post_ovf", 3, 2, 0, 0, 32'd0, 1'b1);
        do_reset("ovf_clear");

        // Reset while waiting for the core after the first block.
        msg_q.delete();
        m_dly = 10;
        m_lag = 0;
        b0 = blk_log.size();
        send_words(16, 1'b0, 0, 32'd0);
        cyc = 0;
        while (blk_log.size() == b0 && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("midrst_issued", 512'(blk_log.size() - b0), 512'd1);
        repeat (3) @(negedge clk);
        chk("midrst_busy_before", 512'(bus.busy), 512'd1);
        do_reset("midrst");
        run_msg("after_rst", 1, 2, 0, 0, 32'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sha_stream_padder.md
Name: sha_stream_padder

Overview:
- Word-stream front end for the SHA-256 core in the MCSE boot path; sits between the boot control logic (word producer) and the SHA core ports (sha_block/sha_init/sha_next).
- Packs 32-bit big-endian message words into 512-bit blocks and applies FIPS 180-4 padding: 0x80000000 word, zero fill, 64-bit bit length.
- Sequences sha_init/sha_next against sha_ready, then captures the final digest.
- Messages are whole 32-bit words only.

Parameters:
- MAX_WORDS, 65536, maximum message length in words; sets the internal word-counter width to $clog2(MAX_WORDS)+1.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- msg_valid  input  1  message word valid
- msg_ready  output  1  padder accepts word this cycle
- msg_data  input  32  message word, big-endian
- msg_last  input  1  final word of message
- sha_ready  input  1  SHA core idle
- sha_digest_valid  input  1  SHA digest valid
- sha_digest  input  256  SHA digest
- sha_block  output  512  block to SHA core
- sha_init  output  1  one-cycle pulse, first block
- sha_next  output  1  one-cycle pulse, subsequent blocks
- digest_out  output  256  captured digest
- digest_done  output  1  one-cycle pulse, digest_out valid
- busy  output  1  message in progress
- overflow_err  output  1  sticky; message exceeded MAX_WORDS

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; word index 0; length counter 0.
- Word packing: word k of a block occupies sha_block[511-32k -: 32]; index k runs 0..15.
- sha_block holds the register contents and is stable from the issue pulse until the next block starts filling.
- FSM states: IDLE, FILL, ISSUE, WAIT_LO, WAIT_RDY, PAD, LEN, WAIT_DIG.
- IDLE:
  - msg_ready=1.
  - On msg_valid, store word 0; busy=1; set first_blk=1; go to FILL.
  - If msg_last is set on that word, go to PAD instead of FILL.
- FILL:
  - msg_ready=1 while fewer than 16 words are held.
  - Each accepted word increments the word index and the 64-bit bit-length counter by 32.
  - After the 16th word is accepted, go to ISSUE with final_blk=0, regardless of msg_last.
  - If msg_last came with that 16th word, set pad_pending=1.
  - If msg_last is accepted with index n<16, go to PAD.
- PAD (index n = 1..15, or n=0 when pad_pending):
  - Write 0x80000000 at word n; zero words n+1..15.
  - If n<=13: words 14/15 = bit length[63:32]/[31:0]; final_blk=1.
  - If n>=14: final_blk=0; set len_pending.
  - Go to ISSUE.
- LEN: all zeros except words 14/15 = bit length; final_blk=1; go to ISSUE.
- ISSUE:
  - Wait for sha_ready=1.
  - Pulse sha_init if first_blk, otherwise sha_next, for exactly one cycle; clear first_blk.
  - Go to WAIT_LO.
- WAIT_LO: one-cycle guard before sampling sha_ready; go to WAIT_RDY.
- WAIT_RDY: wait for sha_ready=1, then:
  - if final_blk, go to WAIT_DIG;
  - else if pad_pending, go to PAD with n=0;
  - else if len_pending, go to LEN;
  - else clear index and go to FILL.
- WAIT_DIG:
  - On sha_digest_valid, latch digest_out, pulse digest_done, clear busy.
  - Go to IDLE.
  - If sha_ready=1 and sha_digest_valid is already 1, capture in the same cycle.
- msg_ready=0 in every state except IDLE and FILL-not-full, so no word is dropped during issue or wait.
- Overflow: a word accepted when the counter already equals MAX_WORDS sets overflow_err.
  - The FSM aborts to IDLE with no digest_done.
  - overflow_err stays set until rst.
- Reset mid-operation: immediate return to IDLE; any partially issued block is abandoned; the SHA core is re-initialised on the next message via sha_init.

Test Plan:
- Single word 0x61626364 with last -> one sha_init; sha_block = 61626364_80000000, words 2..13 = 0, word14 = 0, word15 = 0x00000020; digest latched on sha_digest_valid; digest_done pulses once.
- 13 words with last -> one block, pad at word 13, word15 = 0x000001A0, only sha_init issued.
- 14 words with last -> block 1: pad at word 14, word15 = 0; block 2 (sha_next): all zero except word15 = 0x000001C0.
- 16 words with last -> block 1 = data (sha_init); block 2 (sha_next) = 80000000, zeros, word15 = 0x00000200.
- 20 words, sha_ready held low 10 cycles after each pulse -> msg_ready=0 during the waits; no words lost; sha_next issued once for block 2; length = 0x280.
- rst asserted while in WAIT_RDY -> all outputs 0 immediately; a following one-word message starts with sha_init.
